scan_chain_ctrl: RTL and testbench
==================================

# scan_chain_ctrl

Scan-chain driver: the controlling end of the scan-flop chain built from the scan-mux + DFF merge cells. It serially loads a parallel test pattern into a chain of `CHAIN_LEN` scan flops, optionally issues one functional capture clock, then shifts the chain contents back out and presents them as a parallel result. It sits on the board-level test/debug path, between a host or bring-up sequencer and the `scan_en`/`scan_d` inputs and last-flop `q` of the chain.

## Interface
- `CHAIN_LEN`, default 8: number of scan flops in the chain; legal range ≥1.
- `clk_i` in 1: clock; same clock as the chain flops.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: request; accepted only when `ready_o`=1.
- `capture_en_i` in 1: sampled with `start_i`; 1 = insert capture cycle, 0 = bypass (chain integrity test).
- `pattern_i` in CHAIN_LEN: pattern; bit k is destined for flop k (flop 0 is nearest `scan_d_o`). Sampled on accept.
- `ready_o` out 1: idle, can accept.
- `done_o` out 1: one-cycle pulse, `result_o` valid.
- `result_o` out CHAIN_LEN: bit k = value read from flop k; held until the next accept.
- `scan_en_o` out 1: drives chain `scan_en_i`.
- `scan_d_o` out 1: drives flop 0 `scan_d_i`.
- `scan_q_i` in 1: `q_o` of flop CHAIN_LEN-1.

## Operation
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE: `ready_o`=1, `scan_en_o`=0. `start_i`=1 → load shift reg from `pattern_i`, latch `capture_en_i`, count←0, → SHIFT_IN.
- SHIFT_IN: `scan_en_o`=1, `scan_d_o`=shift reg MSB (bit CHAIN_LEN-1 first); shift left each cycle. After CHAIN_LEN cycles → CAPTURE if latched capture_en else SHIFT_OUT.
- CAPTURE: exactly one cycle, `scan_en_o`=0, `scan_d_o`=0 → SHIFT_OUT.
- SHIFT_OUT: `scan_en_o`=1, `scan_d_o`=0 (chain flushed to zero). Cycle i (0..CHAIN_LEN-1) samples `scan_q_i` into result bit CHAIN_LEN-1-i on the same edge that shifts the chain. After CHAIN_LEN cycles → DONE.
- DONE: one cycle, `done_o`=1, `scan_en_o`=0 → IDLE.
- Counter width $clog2(CHAIN_LEN+1); terminal compare at CHAIN_LEN-1; no wrap beyond.
- `start_i` outside IDLE ignored (no queueing). `pattern_i`/`capture_en_i` changes after accept have no effect.
- Bypass guarantee: with `capture_en_i`=0 and an intact chain, `result_o` == `pattern_i`.

## Timing
- Reset values: state IDLE, `ready_o`=1, `done_o`=0, `scan_en_o`=0, `scan_d_o`=0, `result_o`=0, counter 0.
- Reset asserted in any state: next edge → IDLE with reset values; partially shifted data discarded, no `done_o`.
- Accept edge = cycle 0. SHIFT_IN cycles 1..N; CAPTURE cycle N+1 (if enabled); SHIFT_OUT next N cycles; `done_o` high in cycle 2N+2 (capture) or 2N+1 (bypass); `ready_o`=1 the following cycle.
- `ready_o` and `done_o` never high together; back-to-back start accepted in first IDLE cycle after DONE.
- All outputs are functions of registered state only (no combinational input→output path).

## Structure
- Package `scan_ctrl_pkg`: state enum `scan_state_e` (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE).
- Sub-module `scan_shift_reg`: CHAIN_LEN-bit parallel-load, serial-in/serial-out register with load/shift enables; instantiated twice (pattern out, result in).

## Test plan
Bench uses a behavioural chain model of CHAIN_LEN scan flops, CHAIN_LEN=8 unless stated.
- Bypass: pattern 0xA5, capture_en=0 → `done_o` in cycle 17, `result_o`=0xA5, `scan_en_o` high cycles 1..16.
- Capture: chain D inputs = ~Q, pattern 0xA5, capture_en=1 → `done_o` in cycle 18, `result_o`=0x5A; `scan_en_o`=0 in cycle 9.
- Busy start: pulse start with 0xFF in cycle 5 of a 0x3C bypass run → ignored, result 0x3C, single `done_o`.
- Reset mid-shift: assert `rst_i` in cycle 4 of SHIFT_IN → next cycle `ready_o`=1, `scan_en_o`=0, `result_o`=0, no `done_o`; new start with 0x81 completes to 0x81.
- Back-to-back: starts 0x01 then 0x80 on first `ready_o` → results 0x01, 0x80; chain all-zero after each SHIFT_OUT.
- CHAIN_LEN=1: pattern 1, bypass → `done_o` in cycle 3, `result_o`=1.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// scan_ctrl_pkg
// Shared types for the scan-chain driver.
//   scan_state_e        : controller state encoding
//   state_drives_chain(): 1 in the states where the chain shifts (scan_en high)
// ---------------------------------------------------------------------------
package scan_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SHIFT_IN  = 3'd1,
      ST_CAPTURE   = 3'd2,
      ST_SHIFT_OUT = 3'd3,
      ST_DONE      = 3'd4
   } scan_state_e;

   // The chain is in scan mode only while a pattern moves in or a result moves out.
   function automatic logic state_drives_chain(input scan_state_e st);
      return (st == ST_SHIFT_IN) || (st == ST_SHIFT_OUT);
   endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// ---------------------------------------------------------------------------
// scan_shift_reg
// WIDTH-bit parallel-load, serial-in / serial-out shift register.
// Shifts towards the MSB: the MSB is the serial output, ser_i enters at bit 0.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (clears contents)
//   load_i       : parallel load from par_i (takes priority over shift)
//   par_i        : parallel load data
//   shift_i      : shift one position towards the MSB, ser_i into bit 0
//   ser_i        : serial input
//   par_o        : register contents
//   ser_o        : register MSB
// ---------------------------------------------------------------------------
module scan_shift_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] par_i,
   input  logic             shift_i,
   input  logic             ser_i,
   output logic [WIDTH-1:0] par_o,
   output logic             ser_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] shifted;

   // A one-bit register has no lower bits to keep; it simply takes ser_i.
   generate
      if (WIDTH == 1) begin : g_one
         assign shifted = ser_i;
      end else begin : g_multi
         assign shifted = {data_q[WIDTH-2:0], ser_i};
      end
   endgenerate

   // Next-state selection: load wins over shift, otherwise hold.
   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = par_i;
      end else if (shift_i) begin
         data_d = shifted;
      end else begin
         data_d = data_q;
      end
   end

   // Storage with synchronous clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign par_o = data_q;
   assign ser_o = data_q[WIDTH-1];

endmodule

// File: rtl/scan_chain_ctrl.sv
// ---------------------------------------------------------------------------
// scan_chain_ctrl
// Controlling end of a scan-flop chain. Loads a parallel pattern serially into
// the chain, optionally applies one functional capture cycle, then shifts the
// chain back out (flushing it with zeros) and presents the parallel result.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   start_i       : request, accepted only while ready_o = 1
//   capture_en_i  : sampled with start_i; 1 = insert capture cycle
//   pattern_i     : bit k is destined for chain flop k (flop 0 next to scan_d_o)
//   ready_o       : idle, can accept a request
//   done_o        : one-cycle pulse, result_o valid
//   result_o      : bit k = value read from chain flop k
//   scan_en_o     : chain scan enable
//   scan_d_o      : serial data into chain flop 0
//   scan_q_i      : q of chain flop CHAIN_LEN-1
// All outputs are decoded from registers only.
// ---------------------------------------------------------------------------
module scan_chain_ctrl
   import scan_ctrl_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 capture_en_i,
   input  logic [CHAIN_LEN-1:0] pattern_i,
   output logic                 ready_o,
   output logic                 done_o,
   output logic [CHAIN_LEN-1:0] result_o,
   output logic                 scan_en_o,
   output logic                 scan_d_o,
   input  logic                 scan_q_i
);

   localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   scan_state_e      state_q;
   scan_state_e      state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             cap_q;
   logic             cap_d;

   logic             accept;
   logic             cnt_last;
   logic             pat_shift;
   logic             res_shift;
   logic             pat_ser;
   logic [CHAIN_LEN-1:0] pat_par_unused;
   logic                 res_ser_unused;

   assign accept    = (state_q == ST_IDLE) && start_i;
   assign cnt_last  = (cnt_q == CNT_LAST);
   assign pat_shift = (state_q == ST_SHIFT_IN);
   assign res_shift = (state_q == ST_SHIFT_OUT);

   // Outgoing pattern: loaded on accept, MSB leaves first towards flop 0, so
   // after CHAIN_LEN shifts pattern bit k sits in flop k.
   scan_shift_reg #(
      .WIDTH (CHAIN_LEN)
   ) u_pattern_sr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (accept),
      .par_i   (pattern_i),
      .shift_i (pat_shift),
      .ser_i   (1'b0),
      .par_o   (pat_par_unused),
      .ser_o   (pat_ser)
   );

   // Incoming result: flop CHAIN_LEN-1 arrives first and ends up at the MSB,
   // so result bit k holds flop k once CHAIN_LEN bits have been collected.
   scan_shift_reg #(
      .WIDTH (CHAIN_LEN)
   ) u_result_sr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (1'b0),
      .par_i   ({CHAIN_LEN{1'b0}}),
      .shift_i (res_shift),
      .ser_i   (scan_q_i),
      .par_o   (result_o),
      .ser_o   (res_ser_unused)
   );

   // Sequencing: each shift phase lasts CHAIN_LEN cycles, the counter is
   // rearmed to zero whenever a shift phase ends so it never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_SHIFT_IN;
               cnt_d   = '0;
               cap_d   = capture_en_i;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT_IN: begin
            if (cnt_last) begin
               cnt_d   = '0;
               state_d = cap_q ? ST_CAPTURE : ST_SHIFT_OUT;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         ST_CAPTURE: begin
            state_d = ST_SHIFT_OUT;
         end
         ST_SHIFT_OUT: begin
            if (cnt_last) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            cap_d   = 1'b0;
         end
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
      end
   end

   assign ready_o   = (state_q == ST_IDLE);
   assign done_o    = (state_q == ST_DONE);
   assign scan_en_o = state_drives_chain(state_q);
   // Zero is driven outside SHIFT_IN so SHIFT_OUT flushes the chain clean.
   assign scan_d_o  = pat_shift & pat_ser;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scan_chain_ctrl
// Drives scan_chain_ctrl (CHAIN_LEN=8 and CHAIN_LEN=1) against a behavioural
// scan chain. A transaction-level model predicts every output per cycle from
// the cycle number since accept; directed runs pin the model with literals.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scan_chain_ctrl;

   localparam int N = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         start;
   logic         cap;
   logic [N-1:0] pat;
   logic         ready, done, sen, sd, sq;
   logic [N-1:0] res;

   logic         start1, cap1;
   logic [0:0]   pat1;
   logic         ready1, done1, sen1, sd1, sq1;
   logic [0:0]   res1;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   logic chk_en = 1'b0;

   scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .capture_en_i(cap),
      .pattern_i(pat), .ready_o(ready), .done_o(done), .result_o(res),
      .scan_en_o(sen), .scan_d_o(sd), .scan_q_i(sq));

   scan_chain_ctrl #(.CHAIN_LEN(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start1), .capture_en_i(cap1),
      .pattern_i(pat1), .ready_o(ready1), .done_o(done1), .result_o(res1),
      .scan_en_o(sen1), .scan_d_o(sd1), .scan_q_i(sq1));

   // Behavioural chain: scan mode shifts toward flop N-1; functional mode
   // either holds (D=Q) or inverts (D=~Q) depending on inv.
   logic [N-1:0] chain = '0;
   logic         inv = 1'b0;
   always @(posedge clk) begin
      if (sen) chain <= {chain[N-2:0], sd};
      else if (inv) chain <= ~chain;
   end
   assign sq = chain[N-1];

   logic chain1 = 1'b0;
   always @(posedge clk) begin
      if (sen1) chain1 <= sd1;
   end
   assign sq1 = chain1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int total(input logic c);
      return c ? 2*N+2 : 2*N+1;
   endfunction

   function automatic logic [N-1:0] expect_res(input logic [N-1:0] p, input logic c, input logic i);
      return (c && i) ? ~p : p;
   endfunction

   // Transaction model: idle/busy plus cycle number since accept.
   logic         m_busy = 1'b0;
   int           m_cyc = 0;
   logic [N-1:0] m_pat = '0;
   logic [N-1:0] m_res = '0;
   logic         m_cap = 1'b0;
   logic         m_inv = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0; m_cyc <= 0; m_res <= '0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy <= 1'b1; m_cyc <= 1; m_pat <= pat; m_cap <= cap; m_inv <= inv;
         end
      end else if (m_cyc == total(m_cap)) begin
         m_busy <= 1'b0;
         m_res  <= expect_res(m_pat, m_cap, m_inv);
      end else begin
         m_cyc <= m_cyc + 1;
      end
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      int   so;
      logic exp_en, exp_d;
      if (chk_en) begin
         if (!m_busy) begin
            check("idle_ready", 32'(ready), 32'd1);
            check("idle_done",  32'(done),  32'd0);
            check("idle_scan_en", 32'(sen), 32'd0);
            check("idle_scan_d",  32'(sd),  32'd0);
            check("idle_result",  32'(res), 32'(m_res));
         end else begin
            so     = m_cap ? N+2 : N+1;
            exp_en = (m_cyc <= N) || (m_cyc >= so && m_cyc < so+N);
            exp_d  = (m_cyc <= N) ? m_pat[N-m_cyc] : 1'b0;
            check("busy_ready", 32'(ready), 32'd0);
            check("busy_done",  32'(done),  32'(m_cyc == total(m_cap)));
            check("busy_scan_en", 32'(sen), 32'(exp_en));
            check("busy_scan_d",  32'(sd),  32'(exp_d));
            if (m_cyc == total(m_cap)) begin
               check("done_result", 32'(res), 32'(expect_res(m_pat, m_cap, m_inv)));
               check("chain_flushed", 32'(chain), 32'd0);
            end
         end
      end
   end

   // One request; busy_at / rst_at inject a start pulse or a reset in that cycle.
   task automatic run_txn(input logic [N-1:0] p, input logic c, input int busy_at,
                          input int rst_at, output int done_cyc, output logic [N-1:0] got,
                          output int sen_cnt, output logic [63:0] sen_tr);
      int w = 0;
      while (!ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      if (!ready) check("ready_timeout", 32'd0, 32'd1);
      pat = p; cap = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      done_cyc = -1; got = '0; sen_cnt = 0; sen_tr = '0;
      for (int k = 1; k <= 60; k++) begin
         pat   = N'($urandom);
         cap   = 1'($urandom_range(1, 0));
         start = (k == busy_at);
         if (k == busy_at) pat = '1;
         rst   = (k == rst_at);
         @(negedge clk);
         sen_tr[k] = sen;
         if (sen) sen_cnt++;
         if (done && done_cyc < 0) begin
            done_cyc = k; got = res;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (k == rst_at) begin
            rst = 1'b0;
            break;
         end
         if (done_cyc >= 0) break;
      end
      if (done_cyc < 0 && rst_at <= 0) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int           dc, sc, d0, c1;
      logic [N-1:0] got;
      logic [63:0]  tr;
      logic [N-1:0] rp;
      logic         rc;

      rst = 1'b1; start = 1'b0; cap = 1'b0; pat = '0;
      start1 = 1'b0; cap1 = 1'b0; pat1 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_ready",   32'(ready), 32'd1);
      check("rst_done",    32'(done),  32'd0);
      check("rst_scan_en", 32'(sen),   32'd0);
      check("rst_scan_d",  32'(sd),    32'd0);
      check("rst_result",  32'(res),   32'd0);
      check("rst_ready1",  32'(ready1), 32'd1);
      chk_en = 1'b1;

      // Bypass 0xA5
      run_txn(8'hA5, 1'b0, 0, 0, dc, got, sc, tr);
      check("byp_done_cyc", 32'(dc), 32'd17);
      check("byp_result",   32'(got), 32'hA5);
      check("byp_scan_en_cnt", 32'(sc), 32'd16);
      check("byp_scan_en_c16", 32'(tr[16]), 32'd1);

      // Capture with inverting chain
      inv = 1'b1;
      run_txn(8'hA5, 1'b1, 0, 0, dc, got, sc, tr);
      check("cap_done_cyc", 32'(dc), 32'd18);
      check("cap_result",   32'(got), 32'h5A);
      check("cap_scan_en_c9", 32'(tr[9]), 32'd0);
      check("cap_scan_en_cnt", 32'(sc), 32'd16);
      inv = 1'b0;

      // Start while busy is ignored
      d0 = done_cnt;
      run_txn(8'h3C, 1'b0, 5, 0, dc, got, sc, tr);
      check("busy_result", 32'(got), 32'h3C);
      check("busy_done_cyc", 32'(dc), 32'd17);
      repeat (20) @(posedge clk);
      #1 check("busy_single_done", 32'(done_cnt - d0), 32'd1);

      // Reset in cycle 4 of SHIFT_IN
      d0 = done_cnt;
      run_txn(8'h5A, 1'b0, 0, 4, dc, got, sc, tr);
      check("rst_mid_ready",   32'(ready), 32'd1);
      check("rst_mid_scan_en", 32'(sen),   32'd0);
      check("rst_mid_result",  32'(res),   32'd0);
      repeat (25) @(posedge clk);
      #1 check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
      run_txn(8'h81, 1'b0, 0, 0, dc, got, sc, tr);
      check("rst_after_result", 32'(got), 32'h81);

      // Back-to-back
      run_txn(8'h01, 1'b0, 0, 0, dc, got, sc, tr);
      check("b2b_first", 32'(got), 32'h01);
      check("b2b_chain0_a", 32'(chain), 32'd0);
      run_txn(8'h80, 1'b0, 0, 0, dc, got, sc, tr);
      check("b2b_second", 32'(got), 32'h80);
      check("b2b_first_cyc", 32'(dc), 32'd17);
      check("b2b_chain0_b", 32'(chain), 32'd0);

      // Randomised transactions
      for (int t = 0; t < 24; t++) begin
         repeat ($urandom_range(3, 0)) @(posedge clk);
         #1;
         inv = 1'($urandom_range(1, 0));
         rp  = N'($urandom);
         rc  = 1'($urandom_range(1, 0));
         run_txn(rp, rc, (t % 3 == 0) ? int'($urandom_range(12, 2)) : 0, 0, dc, got, sc, tr);
         check("rnd_done_cyc", 32'(dc), 32'(total(rc)));
         check("rnd_result", 32'(got), 32'(expect_res(rp, rc, inv)));
      end
      inv = 1'b0;

      // CHAIN_LEN = 1
      for (int m = 0; m < 2; m++) begin
         @(posedge clk); #1;
         pat1 = (m == 0) ? 1'b1 : 1'b0;
         cap1 = (m == 1);
         start1 = 1'b1;
         @(posedge clk); #1;
         start1 = 1'b0;
         c1 = -1;
         for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done1 && c1 < 0) begin
               c1 = k;
               check("n1_result", 32'(res1), 32'(m == 0));
            end
            @(posedge clk); #1;
            if (c1 >= 0) break;
         end
         check("n1_done_cyc", 32'(c1), (m == 0) ? 32'd3 : 32'd4);
         check("n1_ready_after", 32'(ready1), 32'd1);
      end

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
